// File: rtl/chain_link_scheduler.sv
// chain_link_scheduler: buffers chain-code bytes from the encoder and frames
// them for TX_UART as SOF, start_x, start_y, codes, perimeter, area,
// checksum, EOF. Encoder errors and FIFO overflows replace the frame tail
// with a single ABORT_BYTE.
module chain_link_scheduler #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  SOF_BYTE   = 8'hA5,
  parameter logic [7:0]  EOF_BYTE   = 8'h5A,
  parameter logic [7:0]  ABORT_BYTE = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  code,
  input  logic        code_valid,
  input  logic        frame_end,
  input  logic        enc_error,
  input  logic [5:0]  start_x,
  input  logic [5:0]  start_y,
  input  logic [8:0]  perimeter,
  input  logic [11:0] area,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, HDR, BODY, TRL, ABORT} state_t;

  state_t      state, state_nx;

  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        fifo_empty, fifo_full;

  logic [5:0]  sx_q, sy_q;
  logic [8:0]  per_q;
  logic [11:0] area_q;
  logic        fe_latch;
  logic [7:0]  csum;

  logic [1:0]  hdr_idx;
  logic [2:0]  trl_idx;
  logic [1:0]  guard_cnt;
  logic        eof_sent;

  logic        pending, in_csum, overflow, abort, slot, push, pop, frame_start;
  logic [7:0]  tx_byte;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign frame_start = (state == IDLE) && code_valid;
  assign busy        = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Byte selection, send-slot decision, abort detection and next state.
  // Abort is resolved before the slot so an error always wins over a send.
  always_comb begin
    state_nx = state;
    pending  = 1'b0;
    tx_byte  = '0;
    in_csum  = 1'b0;
    case (state)
      HDR: begin
        pending = 1'b1;
        case (hdr_idx)
          2'd0:    tx_byte = SOF_BYTE;
          2'd1:    begin tx_byte = {2'b00, sx_q}; in_csum = 1'b1; end
          default: begin tx_byte = {2'b00, sy_q}; in_csum = 1'b1; end
        endcase
      end
      BODY: begin
        pending = !fifo_empty;
        tx_byte = mem[rd_ptr[AW-1:0]];
        in_csum = 1'b1;
      end
      TRL: begin
        pending = 1'b1;
        case (trl_idx)
          3'd0:    begin tx_byte = {7'b0, per_q[8]};    in_csum = 1'b1; end
          3'd1:    begin tx_byte = per_q[7:0];          in_csum = 1'b1; end
          3'd2:    begin tx_byte = {4'b0, area_q[11:8]}; in_csum = 1'b1; end
          3'd3:    begin tx_byte = area_q[7:0];         in_csum = 1'b1; end
          3'd4:    tx_byte = csum;
          default: tx_byte = EOF_BYTE;
        endcase
      end
      ABORT: begin
        pending = 1'b1;
        tx_byte = ABORT_BYTE;
      end
      default: ;
    endcase

    overflow = code_valid && ((state == TRL) ||
               (((state == HDR) || (state == BODY)) && fifo_full));
    abort    = overflow || (enc_error && (state != IDLE));
    slot     = pending && tx_ready && (guard_cnt == 2'd0) && !abort;
    push     = code_valid && !abort &&
               ((state == IDLE) || (state == HDR) || (state == BODY));
    pop      = slot && (state == BODY);

    if (abort) begin
      state_nx = ABORT;
    end else begin
      case (state)
        IDLE:  if (code_valid) state_nx = HDR;
        HDR:   if (slot && (hdr_idx == 2'd2)) state_nx = BODY;
        // A code arriving in the same cycle must still go out before the trailer
        BODY:  if (fe_latch && fifo_empty && !code_valid) state_nx = TRL;
        TRL:   if (slot && (trl_idx == 3'd5)) state_nx = IDLE;
        ABORT: if (slot) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FIFO pointers; an abort flushes all buffered codes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= code;
  end

  // Per-frame context: start point, trailer values, checksum, sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sx_q     <= '0;
      sy_q     <= '0;
      per_q    <= '0;
      area_q   <= '0;
      fe_latch <= 1'b0;
      csum     <= '0;
      err      <= 1'b0;
    end else begin
      if (frame_start) begin
        sx_q     <= start_x;
        sy_q     <= start_y;
        fe_latch <= 1'b0;
        csum     <= '0;
      end else begin
        if (((state == HDR) || (state == BODY)) && frame_end) begin
          fe_latch <= 1'b1;
          per_q    <= perimeter;
          area_q   <= area;
        end
        if (slot && in_csum) csum <= csum ^ tx_byte;
      end
      if (abort || ((state == IDLE) && enc_error)) err <= 1'b1;
      else if (frame_start)                        err <= 1'b0;
    end
  end

  // Transmit handshake, ready guard, byte indices and frame_done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data    <= '0;
      tx_start   <= 1'b0;
      guard_cnt  <= '0;
      hdr_idx    <= '0;
      trl_idx    <= '0;
      eof_sent   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_start <= slot;
      if (slot) tx_data <= tx_byte;
      if (slot)                   guard_cnt <= 2'd2;
      else if (guard_cnt != 2'd0) guard_cnt <= guard_cnt - 2'd1;
      if (state_nx != state) begin
        hdr_idx <= '0;
        trl_idx <= '0;
      end else if (slot) begin
        if (state == HDR) hdr_idx <= hdr_idx + 2'd1;
        if (state == TRL) trl_idx <= trl_idx + 3'd1;
      end
      eof_sent   <= slot && (state == TRL) && (trl_idx == 3'd5);
      frame_done <= eof_sent;
    end
  end

endmodule

// File: tb/tb_chain_link_scheduler.sv
// Testbench for chain_link_scheduler: table-driven frames, hand-written
// corner sequences and randomized frames checked against a frame model.
module tb_chain_link_scheduler;

  localparam int unsigned DEPTH = 16;
  localparam logic [7:0]  SOF   = 8'hA5;
  localparam logic [7:0]  EOF   = 8'h5A;
  localparam logic [7:0]  ABT   = 8'hEE;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  code = '0;
  logic        code_valid = 1'b0;
  logic        frame_end = 1'b0;
  logic        enc_error = 1'b0;
  logic [5:0]  start_x = '0;
  logic [5:0]  start_y = '0;
  logic [8:0]  perimeter = '0;
  logic [11:0] area = '0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        frame_done;
  logic        err;

  chain_link_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .SOF_BYTE  (SOF),
    .EOF_BYTE  (EOF),
    .ABORT_BYTE(ABT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .code      (code),
    .code_valid(code_valid),
    .frame_end (frame_end),
    .enc_error (enc_error),
    .start_x   (start_x),
    .start_y   (start_y),
    .perimeter (perimeter),
    .area      (area),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    logic [5:0]      sx;
    logic [5:0]      sy;
    int              n;
    logic [2:0][7:0] codes;
    logic [8:0]      per;
    logic [11:0]     ar;
    logic [4:0][7:0] trl;  // per_hi, per_lo, area_hi, area_lo, checksum
  } vec_t;

  int   npass = 0;
  int   ntotal = 0;
  bq_t  got;
  int   fd_count = 0;
  int   cyc = 0;
  int   last_start = -1000;
  bit   rnd_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transmit monitor: collects bytes, checks ready guard spacing and frame_done timing
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      last_start = -1000;
    end else begin
      if (frame_done) begin
        fd_count++;
        check("frame_done one cycle after EOF start", cyc - last_start, 1);
        check("frame_done follows EOF byte",
              (got.size() > 0) ? int'(got[got.size()-1]) : -1, int'(EOF));
      end
      if (tx_start) begin
        check("tx_start spacing", int'(cyc - last_start >= 3), 1);
        last_start = cyc;
        got.push_back(tx_data);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bq_t model_frame(input logic [5:0] sx, input logic [5:0] sy,
                                      input bq_t codes, input logic [8:0] per,
                                      input logic [11:0] ar);
    bq_t        payload;
    bq_t        f;
    logic [7:0] x;
    payload.push_back({2'b00, sx});
    payload.push_back({2'b00, sy});
    foreach (codes[i]) payload.push_back(codes[i]);
    payload.push_back(8'(per >> 8));
    payload.push_back(8'(per % 256));
    payload.push_back(8'(ar >> 8));
    payload.push_back(8'(ar % 256));
    x = '0;
    foreach (payload[i]) x = x ^ payload[i];
    f.push_back(SOF);
    foreach (payload[i]) f.push_back(payload[i]);
    f.push_back(x);
    f.push_back(EOF);
    return f;
  endfunction

  function automatic vec_t mk(input logic [5:0] sx, input logic [5:0] sy, input int n,
                              input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [8:0] per, input logic [11:0] ar,
                              input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                              input logic [7:0] t3, input logic [7:0] t4);
    vec_t r;
    r.sx = sx; r.sy = sy; r.n = n;
    r.codes[0] = c0; r.codes[1] = c1; r.codes[2] = c2;
    r.per = per; r.ar = ar;
    r.trl[0] = t0; r.trl[1] = t1; r.trl[2] = t2; r.trl[3] = t3; r.trl[4] = t4;
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_code(input logic [7:0] c, input logic [5:0] sx, input logic [5:0] sy);
    code = c; start_x = sx; start_y = sy; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
  endtask

  task automatic drive_frame_end(input logic [8:0] per, input logic [11:0] ar);
    perimeter = per; area = ar; frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    step();
    while (busy && n < 3000) begin step(); n++; end
    check({name, " returns idle"}, int'(busy), 0);
    repeat (4) step();
  endtask

  task automatic wait_bytes(input string name, input int n);
    int k = 0;
    while (got.size() < n && k < 2000) begin step(); k++; end
    check({name, " bytes reached"}, int'(got.size() >= n), 1);
  endtask

  task automatic compare_stream(input string name, input bq_t exp);
    check({name, " length"}, got.size(), exp.size());
    foreach (exp[i])
      if (i < got.size())
        check($sformatf("%s byte %0d", name, i), int'(got[i]), int'(exp[i]));
  endtask

  task automatic run_frame(input string name, input logic [5:0] sx, input logic [5:0] sy,
                           input bq_t codes, input logic [8:0] per, input logic [11:0] ar,
                           input bq_t exp);
    int fd0;
    got.delete();
    fd0 = fd_count;
    foreach (codes[i]) begin
      drive_code(codes[i], sx, sy);
      repeat ($urandom_range(0, 2)) step();
    end
    drive_frame_end(per, ar);
    wait_idle(name);
    compare_stream(name, exp);
    check({name, " frame_done count"}, fd_count - fd0, 1);
    check({name, " err"}, int'(err), 0);
  endtask

  initial begin
    vec_t       vecs [3];
    bq_t        codes;
    bq_t        exp;
    int         fd0;
    logic [5:0] rsx, rsy;
    logic [8:0] rper;
    logic [11:0] rar;
    int         n;

    // Checksums are the XOR of start_x, start_y, codes and the four
    // perimeter/area bytes, e.g. 05^09^01^02^03^00^03^00^12 = 1D.
    vecs[0] = mk(6'd5,  6'd9, 3, 8'h01, 8'h02, 8'h03, 9'h003, 12'h012,
                 8'h00, 8'h03, 8'h00, 8'h12, 8'h1D);
    vecs[1] = mk(6'd0,  6'd0, 1, 8'h07, 8'h00, 8'h00, 9'h1FF, 12'hFFF,
                 8'h01, 8'hFF, 8'h0F, 8'hFF, 8'h09);
    vecs[2] = mk(6'd63, 6'd1, 2, 8'h80, 8'h40, 8'h00, 9'h100, 12'h800,
                 8'h01, 8'h00, 8'h08, 8'h00, 8'hF7);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs zero", int'({tx_data, tx_start, busy, frame_done, err}), 0);
    reset = 1'b1;
    step();

    // Table-driven frames with tx_ready held high
    for (int v = 0; v < 3; v++) begin
      codes.delete(); exp.delete();
      exp.push_back(SOF);
      exp.push_back({2'b00, vecs[v].sx});
      exp.push_back({2'b00, vecs[v].sy});
      for (int k = 0; k < vecs[v].n; k++) begin
        codes.push_back(vecs[v].codes[k]);
        exp.push_back(vecs[v].codes[k]);
      end
      for (int k = 0; k < 5; k++) exp.push_back(vecs[v].trl[k]);
      exp.push_back(EOF);
      run_frame($sformatf("vec%0d", v), vecs[v].sx, vecs[v].sy, codes,
                vecs[v].per, vecs[v].ar, exp);
    end

    // Back-pressure: tx_ready low for 50 cycles in BODY while 9 more codes arrive
    got.delete(); fd0 = fd_count; codes.delete();
    codes.push_back(8'h30);
    drive_code(8'h30, 6'd10, 6'd20);
    wait_bytes("backpressure", 4);
    tx_ready = 1'b0;
    for (int i = 1; i < 10; i++) begin
      codes.push_back(8'(8'h30 + i));
      drive_code(8'(8'h30 + i), 6'd10, 6'd20);
      step();
    end
    repeat (32) step();
    check("backpressure no send while stalled", got.size(), 4);
    tx_ready = 1'b1;
    drive_frame_end(9'h0AA, 12'h155);
    wait_idle("backpressure");
    compare_stream("backpressure", model_frame(6'd10, 6'd20, codes, 9'h0AA, 12'h155));
    check("backpressure err", int'(err), 0);
    check("backpressure frame_done count", fd_count - fd0, 1);

    // Overflow: DEPTH codes fill the FIFO, one more aborts
    got.delete(); fd0 = fd_count;
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) drive_code(8'(i + 1), 6'd1, 6'd2);
    check("full FIFO is not overflow", int'(err), 0);
    drive_code(8'hFF, 6'd1, 6'd2);
    step();
    check("overflow err", int'(err), 1);
    check("overflow busy while stalled", int'(busy), 1);
    check("overflow nothing sent while stalled", got.size(), 0);
    tx_ready = 1'b1;
    wait_idle("overflow");
    exp.delete(); exp.push_back(ABT);
    compare_stream("overflow", exp);
    check("overflow no frame_done", fd_count - fd0, 0);
    check("overflow err sticky", int'(err), 1);

    // Encoder error in BODY with two codes queued: they must be flushed
    got.delete(); fd0 = fd_count;
    drive_code(8'h11, 6'd3, 6'd4);
    wait_bytes("enc_error", 4);
    tx_ready = 1'b0;
    drive_code(8'h22, 6'd3, 6'd4);
    drive_code(8'h33, 6'd3, 6'd4);
    enc_error = 1'b1;
    step();
    enc_error = 1'b0;
    check("enc_error err", int'(err), 1);
    tx_ready = 1'b1;
    wait_idle("enc_error");
    exp.delete();
    exp.push_back(SOF); exp.push_back(8'h03); exp.push_back(8'h04);
    exp.push_back(8'h11); exp.push_back(ABT);
    compare_stream("enc_error", exp);
    check("enc_error no frame_done", fd_count - fd0, 0);

    // Next frame clears err and carries none of the flushed codes
    got.delete(); fd0 = fd_count; codes.delete();
    codes.push_back(8'h55); codes.push_back(8'h66);
    drive_code(8'h55, 6'd2, 6'd3);
    check("frame start clears err", int'(err), 0);
    drive_code(8'h66, 6'd2, 6'd3);
    drive_frame_end(9'h010, 12'h020);
    wait_idle("after_error");
    compare_stream("after_error", model_frame(6'd2, 6'd3, codes, 9'h010, 12'h020));
    check("after_error frame_done count", fd_count - fd0, 1);

    // Reset asserted asynchronously while in the trailer
    got.delete(); fd0 = fd_count;
    drive_code(8'h44, 6'd7, 6'd8);
    drive_frame_end(9'h1AB, 12'h345);
    wait_bytes("reset_trl", 5);
    #2;
    reset = 1'b0;
    #1;
    check("async reset outputs zero", int'({tx_data, tx_start, busy, frame_done, err}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    step();
    check("reset_trl no frame_done", fd_count - fd0, 0);
    codes.delete();
    codes.push_back(8'h01); codes.push_back(8'h02); codes.push_back(8'h03);
    run_frame("after_reset", 6'd5, 6'd9, codes, 9'h003, 12'h012,
              model_frame(6'd5, 6'd9, codes, 9'h003, 12'h012));

    // Randomized frames with random ready stalls
    rnd_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      codes.delete();
      rsx  = 6'($urandom);
      rsy  = 6'($urandom);
      rper = 9'($urandom);
      rar  = 12'($urandom);
      n    = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) codes.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), rsx, rsy, codes, rper, rar,
                model_frame(rsx, rsy, codes, rper, rar));
    end
    rnd_ready = 1'b0;
    tx_ready  = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
